exhaustive_response_checker: RTL and testbench

Hardware counterpart to the exhaustive-stimulus benches used for trojan detection. It drives every N_IN-bit input pattern, from 0 to 2^N_IN−1 in ascending order, into a single-output DUT. It samples the DUT response after a fixed latency and compares it against a golden truth table loaded beforehand. It reports pass/fail, the mismatch count and the first failing pattern, so a sweep can be checked on-chip or in emulation instead of by post-processing a dump file.

---
 rtl/exhaustive_response_checker_if.sv | 30 +++
 rtl/exhaustive_response_checker.sv | 127 ++++++++++++
 tb/tb_exhaustive_response_checker.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/exhaustive_response_checker_if.sv
// Bundle between the exhaustive response checker and its driver.
// Carries sweep control, golden-table writes, DUT stimulus/response and results.
interface exhaustive_response_checker_if #(
    parameter int N_IN = 4
);
    logic            start;
    logic            golden_wr;
    logic [N_IN-1:0] golden_addr;
    logic            golden_bit;
    logic [N_IN-1:0] pattern;
    logic            dut_out;
    logic            busy;
    logic            done;
    logic            pass;
    logic [N_IN:0]   mismatch_cnt;
    logic [N_IN-1:0] first_fail;
    logic            first_fail_vld;

    modport master (
        output start, golden_wr, golden_addr, golden_bit, dut_out,
        input  pattern, busy, done, pass, mismatch_cnt,
        input  first_fail, first_fail_vld
    );

    modport slave (
        input  start, golden_wr, golden_addr, golden_bit, dut_out,
        output pattern, busy, done, pass, mismatch_cnt,
        output first_fail, first_fail_vld
    );
endinterface

// File: rtl/exhaustive_response_checker.sv
// Sweeps every N_IN-bit pattern into a DUT and compares the delayed
// response against a golden truth table, keeping count and first failure.
module exhaustive_response_checker #(
    parameter int N_IN = 4,
    parameter int LAT  = 1
) (
    input logic CK,
    input logic reset,
    exhaustive_response_checker_if.slave bus
);
    localparam int NP = 1 << N_IN;
    localparam logic [N_IN-1:0] P_LAST = '1;
    localparam logic [N_IN-1:0] P_ONE  = 1;
    localparam logic [N_IN:0]   C_ONE  = 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [NP-1:0]   r_golden;
    logic [N_IN-1:0] r_pattern;
    logic            r_iss;
    logic [N_IN:0]   r_cnt;
    logic [N_IN-1:0] r_ff;
    logic            r_ffv;

    logic            w_cv;
    logic [N_IN-1:0] w_ck;
    logic            w_mis;
    logic            w_last_cmp;
    logic            w_run;

    // Index/valid delay line aligning each issued pattern with its response
    generate
        if (LAT == 1) begin : g_comb
            assign w_cv = r_iss;
            assign w_ck = r_pattern;
        end else begin : g_pipe
            logic            r_pv [LAT-1];
            logic [N_IN-1:0] r_pk [LAT-1];

            always_ff @(posedge CK or negedge reset) begin
                if (!reset) begin
                    for (int i = 0; i < LAT - 1; i++) begin
                        r_pv[i] <= 1'b0;
                        r_pk[i] <= '0;
                    end
                end else begin
                    r_pv[0] <= r_iss;
                    r_pk[0] <= r_pattern;
                    for (int i = 1; i < LAT - 1; i++) begin
                        r_pv[i] <= r_pv[i-1];
                        r_pk[i] <= r_pk[i-1];
                    end
                end
            end

            assign w_cv = r_pv[LAT-2];
            assign w_ck = r_pk[LAT-2];
        end
    endgenerate

    assign w_run      = (r_state == S_RUN);
    assign w_mis      = w_cv & (bus.dut_out ^ r_golden[w_ck]);
    assign w_last_cmp = w_cv && (w_ck == P_LAST);

    always_ff @(posedge CK or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (bus.start) w_next = S_RUN;
            S_RUN:   if (w_last_cmp) w_next = S_DONE;
            S_DONE:  if (bus.start) w_next = S_RUN;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            r_golden  <= '0;
            r_pattern <= '0;
            r_iss     <= 1'b0;
            r_cnt     <= '0;
            r_ff      <= '0;
            r_ffv     <= 1'b0;
        end else begin
            if (bus.golden_wr && !w_run)
                r_golden[bus.golden_addr] <= bus.golden_bit;
            if (!w_run && bus.start) begin
                r_pattern <= '0;
                r_iss     <= 1'b1;
                r_cnt     <= '0;
                r_ff      <= '0;
                r_ffv     <= 1'b0;
            end else if (w_run) begin
                if (r_iss) begin
                    if (r_pattern == P_LAST) r_iss <= 1'b0;
                    else r_pattern <= r_pattern + P_ONE;
                end
                if (w_mis) begin
                    r_cnt <= r_cnt + C_ONE;
                    if (!r_ffv) begin
                        r_ff  <= w_ck;
                        r_ffv <= 1'b1;
                    end
                end
                if (w_last_cmp) r_pattern <= '0;
            end
        end
    end

    assign bus.pattern        = r_pattern;
    assign bus.busy           = w_run;
    assign bus.done           = (r_state == S_DONE);
    assign bus.pass           = (r_state == S_DONE) && (r_cnt == '0);
    assign bus.mismatch_cnt   = r_cnt;
    assign bus.first_fail     = r_ff;
    assign bus.first_fail_vld = r_ffv;
endmodule

// File: tb/tb_exhaustive_response_checker.sv
// Directed bench for exhaustive_response_checker: one LAT=1 instance
// driving a selectable combinational DUT, one LAT=3 instance with a piped AND.
module tb_exhaustive_response_checker;
    logic CK = 1'b0;
    logic reset = 1'b0;
    always #5 CK = ~CK;

    exhaustive_response_checker_if #(.N_IN(4)) ifa ();
    exhaustive_response_checker_if #(.N_IN(4)) ifb ();

    exhaustive_response_checker #(.N_IN(4), .LAT(1)) u_a (
        .CK(CK), .reset(reset), .bus(ifa)
    );
    exhaustive_response_checker #(.N_IN(4), .LAT(3)) u_b (
        .CK(CK), .reset(reset), .bus(ifb)
    );

    int mode = 0;
    assign ifa.dut_out = (mode == 1) ? (&ifa.pattern) :
                         (mode == 2) ? ~(&ifa.pattern) : 1'b0;

    logic r1, r2;
    always_ff @(posedge CK) begin
        r1 <= &ifb.pattern;
        r2 <= r1;
    end
    assign ifb.dut_out = r2;

    int n_assert = 0;
    int n_fail = 0;
    int len;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr_a(input logic [3:0] a, input logic b);
        ifa.golden_wr = 1'b1;
        ifa.golden_addr = a;
        ifa.golden_bit = b;
        @(negedge CK);
        ifa.golden_wr = 1'b0;
    endtask

    task automatic sweep_a(input bit inj, output int n);
        ifa.start = 1'b1;
        @(negedge CK);
        ifa.start = 1'b0;
        n = 0;
        while (ifa.busy && n < 100) begin
            n++;
            if (inj && n == 3) begin
                ifa.start = 1'b1;
                ifa.golden_wr = 1'b1;
                ifa.golden_addr = 4'd3;
                ifa.golden_bit = 1'b1;
            end
            if (inj && n == 4) begin
                ifa.start = 1'b0;
                ifa.golden_wr = 1'b0;
            end
            @(negedge CK);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pattern"}, ifa.pattern, 0);
        chk({tag, "_busy"}, ifa.busy, 0);
        chk({tag, "_done"}, ifa.done, 0);
        chk({tag, "_pass"}, ifa.pass, 0);
        chk({tag, "_cnt"}, ifa.mismatch_cnt, 0);
        chk({tag, "_ff"}, ifa.first_fail, 0);
        chk({tag, "_ffv"}, ifa.first_fail_vld, 0);
    endtask

    initial begin
        ifa.start = 0; ifa.golden_wr = 0; ifa.golden_addr = 0; ifa.golden_bit = 0;
        ifb.start = 0; ifb.golden_wr = 0; ifb.golden_addr = 0; ifb.golden_bit = 0;
        repeat (3) @(negedge CK);
        chk_reset_vals("rst");
        reset = 1'b1;
        @(negedge CK);

        mode = 0;
        sweep_a(1'b0, len);
        chk("t1_len", len, 16);
        chk("t1_done", ifa.done, 1);
        chk("t1_pass", ifa.pass, 1);
        chk("t1_cnt", ifa.mismatch_cnt, 0);
        chk("t1_ffv", ifa.first_fail_vld, 0);
        chk("t1_pat", ifa.pattern, 0);

        for (int a = 0; a < 16; a++) wr_a(4'(a), a == 15);
        wr_a(4'd5, 1'b1);
        mode = 1;
        sweep_a(1'b0, len);
        chk("t2_pass", ifa.pass, 0);
        chk("t2_cnt", ifa.mismatch_cnt, 1);
        chk("t2_ff", ifa.first_fail, 5);
        chk("t2_ffv", ifa.first_fail_vld, 1);

        wr_a(4'd5, 1'b0);
        mode = 2;
        sweep_a(1'b0, len);
        chk("t3_cnt", ifa.mismatch_cnt, 16);
        chk("t3_ff", ifa.first_fail, 0);
        chk("t3_ffv", ifa.first_fail_vld, 1);
        chk("t3_pass", ifa.pass, 0);

        mode = 1;
        sweep_a(1'b0, len);
        chk("b2b_len", len, 16);
        chk("b2b_pass", ifa.pass, 1);
        chk("b2b_cnt", ifa.mismatch_cnt, 0);
        chk("b2b_ffv", ifa.first_fail_vld, 0);

        ifa.start = 1'b1;
        @(negedge CK);
        ifa.start = 1'b0;
        len = 0;
        while (ifa.pattern != 4'd7 && len < 50) begin
            len++;
            @(negedge CK);
        end
        chk("t5_p7", ifa.pattern, 7);
        #2 reset = 1'b0;
        #1 chk_reset_vals("t5_async");
        @(negedge CK);
        reset = 1'b1;
        @(negedge CK);
        mode = 1;
        sweep_a(1'b0, len);
        chk("t5_cnt", ifa.mismatch_cnt, 1);
        chk("t5_ff", ifa.first_fail, 15);
        chk("t5_pass", ifa.pass, 0);

        mode = 0;
        sweep_a(1'b1, len);
        chk("t6_len", len, 16);
        chk("t6_cnt", ifa.mismatch_cnt, 0);
        chk("t6_pass", ifa.pass, 1);
        wr_a(4'd3, 1'b1);
        sweep_a(1'b0, len);
        chk("t6b_cnt", ifa.mismatch_cnt, 1);
        chk("t6b_ff", ifa.first_fail, 3);

        ifb.golden_wr = 1'b1;
        ifb.golden_addr = 4'd15;
        ifb.golden_bit = 1'b1;
        @(negedge CK);
        ifb.golden_wr = 1'b0;
        ifb.start = 1'b1;
        @(negedge CK);
        ifb.start = 1'b0;
        len = 0;
        while (ifb.busy && len < 100) begin
            len++;
            if (ifb.pass) chk("t4_pass_run", ifb.pass, 0);
            @(negedge CK);
        end
        chk("t4_len", len, 18);
        chk("t4_done", ifb.done, 1);
        chk("t4_pass", ifb.pass, 1);
        chk("t4_cnt", ifb.mismatch_cnt, 0);
        chk("t4_ffv", ifb.first_fail_vld, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end
endmodule
